cp0_regs: RTL and testbench

CP0_REGS -- requirements
Module: cp0_regs

---
 rtl/cp0_regs_pkg.sv | 29 ++
 rtl/cp0_timer.sv | 50 +++++
 rtl/cp0_regs.sv | 139 +++++++++++++
 tb/tb_cp0_regs.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_regs_pkg.sv
// rtl/cp0_regs_pkg.sv - shared CP0 register numbers, exception codes and bus widths
package cp0_regs_pkg;

    // CP0 register numbers (select 0)
    localparam logic [4:0] CR_BADVADDR = 5'd8;
    localparam logic [4:0] CR_COUNT    = 5'd9;
    localparam logic [4:0] CR_COMPARE  = 5'd11;
    localparam logic [4:0] CR_STATUS   = 5'd12;
    localparam logic [4:0] CR_CAUSE    = 5'd13;
    localparam logic [4:0] CR_EPC      = 5'd14;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // WB-to-CP0 bus: wb_ex, wb_excode, wb_bd, wb_pc, wb_badvaddr, eret_flush
    localparam int WB_TO_CP0_BUS_WD = 1 + 5 + 1 + 32 + 32 + 1;

    // Only address-error exceptions carry a meaningful faulting address
    function automatic logic is_addr_exc(input logic [4:0] excode);
        return (excode == EXC_ADEL) || (excode == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with half-rate tick and timer interrupt flag
module cp0_timer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Tick toggles every cycle so Count advances on every second edge; a Count write wins over the increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick  <= 1'b0;
            r_count <= 32'd0;
        end else begin
            r_tick <= ~r_tick;
            if (i_count_we) begin
                r_count <= i_wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Compare write clears TI; otherwise a match against the current Count raises it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else if (i_compare_we) begin
            r_compare <= i_wdata;
            r_ti      <= 1'b0;
        end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule

// File: rtl/cp0_regs.sv
// rtl/cp0_regs.sv - CP0 register file: Status, Cause, EPC, BadVAddr, timer, interrupt detect
module cp0_regs
    import cp0_regs_pkg::*;
#(
    parameter logic [31:0] EX_ENTRY = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        eret_flush,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  ext_int_in,
    output logic [31:0] cp0_rdata,
    output logic [31:0] cp0_epc,
    output logic [31:0] ex_entry,
    output logic        has_int
);

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_excode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic        w_mtc0;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // A committing exception suppresses any MTC0 issued in the same cycle
    assign w_mtc0 = mtc0_we & ~wb_ex;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .i_count_we   (w_mtc0 && (cp0_addr == CR_COUNT)),
        .i_compare_we (w_mtc0 && (cp0_addr == CR_COMPARE)),
        .i_wdata      (cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Status: exception sets EXL, ERET clears it (ERET beats MTC0), MTC0 writes IM/EXL/IE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im  <= 8'd0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (wb_ex) begin
            r_exl <= 1'b1;
        end else begin
            if (w_mtc0 && (cp0_addr == CR_STATUS)) begin
                r_im  <= cp0_wdata[15:8];
                r_exl <= cp0_wdata[1];
                r_ie  <= cp0_wdata[0];
            end
            if (eret_flush) begin
                r_exl <= 1'b0;
            end
        end
    end

    // Cause: hardware IP sampled every cycle, BD only captured on a first-level exception
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bd     <= 1'b0;
            r_ip_hw  <= 6'd0;
            r_ip_sw  <= 2'd0;
            r_excode <= 5'd0;
        end else begin
            r_ip_hw <= {ext_int_in[5] | w_ti, ext_int_in[4:0]};
            if (wb_ex) begin
                r_excode <= wb_excode;
                if (!r_exl) begin
                    r_bd <= wb_bd;
                end
            end else if (w_mtc0 && (cp0_addr == CR_CAUSE)) begin
                r_ip_sw <= cp0_wdata[9:8];
            end
        end
    end

    // EPC points at the branch when the faulting instruction is in its delay slot; nested exceptions keep it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc <= 32'd0;
        end else if (wb_ex) begin
            if (!r_exl) begin
                r_epc <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
        end else if (w_mtc0 && (cp0_addr == CR_EPC)) begin
            r_epc <= cp0_wdata;
        end
    end

    // BadVAddr only captures the address of address-error exceptions
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_badvaddr <= 32'd0;
        end else if (wb_ex && is_addr_exc(wb_excode)) begin
            r_badvaddr <= wb_badvaddr;
        end
    end

    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_excode, 2'b00};

    // Zero-latency MFC0 read mux; unimplemented registers read as zero
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            CR_BADVADDR: cp0_rdata = r_badvaddr;
            CR_COUNT:    cp0_rdata = w_count;
            CR_COMPARE:  cp0_rdata = w_compare;
            CR_STATUS:   cp0_rdata = w_status;
            CR_CAUSE:    cp0_rdata = w_cause;
            CR_EPC:      cp0_rdata = r_epc;
            default:     cp0_rdata = 32'd0;
        endcase
    end

    assign cp0_epc  = r_epc;
    assign ex_entry = EX_ENTRY;
    assign has_int  = (|({r_ip_hw, r_ip_sw} & r_im)) & r_ie & ~r_exl;

endmodule

// File: tb/tb_cp0_regs.sv
// tb/tb_cp0_regs.sv - scoreboard bench for cp0_regs against a behavioural CP0 model
module tb_cp0_regs;
    import cp0_regs_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_ex = 1'b0;
    logic [4:0]  wb_excode = '0;
    logic        wb_bd = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [31:0] wb_badvaddr = '0;
    logic        eret_flush = 1'b0;
    logic        mtc0_we = 1'b0;
    logic [4:0]  cp0_addr = '0;
    logic [31:0] cp0_wdata = '0;
    logic [5:0]  ext_int_in = '0;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [31:0] ex_entry;
    logic        has_int;

    always #5 clk = ~clk;

    cp0_regs #(.EX_ENTRY(32'hBFC0_0380)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .wb_ex       (wb_ex),
        .wb_excode   (wb_excode),
        .wb_bd       (wb_bd),
        .wb_pc       (wb_pc),
        .wb_badvaddr (wb_badvaddr),
        .eret_flush  (eret_flush),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .ext_int_in  (ext_int_in),
        .cp0_rdata   (cp0_rdata),
        .cp0_epc     (cp0_epc),
        .ex_entry    (ex_entry),
        .has_int     (has_int)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] rdata;
        logic [31:0] epc;
        logic        hint;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rst_req = 1'b1;

    // Reference model state, kept as architectural fields
    logic [7:0]  m_im;
    bit          m_ie, m_exl, m_bd, m_ti, m_tick;
    logic [5:0]  m_iphw;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [31:0] m_count, m_compare, m_epc, m_badv;

    task automatic m_reset();
        m_im = 0; m_ie = 0; m_exl = 0; m_bd = 0; m_ti = 0; m_tick = 0;
        m_iphw = 0; m_ipsw = 0; m_exc = 0;
        m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13: return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'({m_iphw, m_ipsw}) << 8) | (32'(m_exc) << 2);
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_hint();
        return ((({m_iphw, m_ipsw} & m_im) != 0) && m_ie && !m_exl);
    endfunction

    task automatic m_step(input bit ex, input logic [4:0] code, input bit bd, input logic [31:0] pc,
                          input logic [31:0] bva, input bit er, input bit we, input logic [4:0] a,
                          input logic [31:0] wd, input logic [5:0] ext);
        bit mw;
        bit old_ti, old_exl, n_ti;
        mw = we && !ex;
        old_ti = m_ti;
        old_exl = m_exl;
        if (mw && a == 5'd11) n_ti = 0;
        else if (m_count == m_compare) n_ti = 1;
        else n_ti = m_ti;
        if (mw && a == 5'd11) m_compare = wd;
        if (mw && a == 5'd9) m_count = wd;
        else if (m_tick) m_count = m_count + 1;
        m_tick = !m_tick;
        m_ti = n_ti;
        m_iphw = {ext[5] | old_ti, ext[4:0]};
        if (ex) begin
            if (!old_exl) begin
                m_bd = bd;
                m_epc = bd ? pc - 4 : pc;
            end
            m_exl = 1;
            m_exc = code;
            if (code == 5'h04 || code == 5'h05) m_badv = bva;
        end else begin
            if (mw && a == 5'd12) begin
                m_im = wd[15:8]; m_exl = wd[1]; m_ie = wd[0];
            end
            if (mw && a == 5'd13) m_ipsw = wd[9:8];
            if (mw && a == 5'd14) m_epc = wd;
            if (er) m_exl = 0;
        end
    endtask

    // One clock cycle of stimulus; the expected outputs for that cycle go to the scoreboard
    task automatic step(input bit ex, input logic [4:0] code, input bit bd, input logic [31:0] pc,
                        input logic [31:0] bva, input bit er, input bit we, input logic [4:0] a,
                        input logic [31:0] wd, input logic [5:0] ext, input bit use_c,
                        input logic [31:0] cval);
        exp_t e;
        @(negedge clk);
        resetn = !rst_req;
        wb_ex = ex; wb_excode = code; wb_bd = bd; wb_pc = pc; wb_badvaddr = bva;
        eret_flush = er; mtc0_we = we; cp0_addr = a; cp0_wdata = wd; ext_int_in = ext;
        if (rst_req) m_reset();
        e.addr = a;
        e.rdata = use_c ? cval : m_read(a);
        e.epc = m_epc;
        e.hint = m_hint();
        sb.push_back(e);
        if (rst_req) m_reset();
        else m_step(ex, code, bd, pc, bva, er, we, a, wd, ext);
    endtask

    task automatic idle(input logic [4:0] a);
        step(0, 0, 0, 0, 0, 0, 0, a, 0, 0, 0, 0);
    endtask

    task automatic idle_c(input logic [4:0] a, input logic [31:0] v);
        step(0, 0, 0, 0, 0, 0, 0, a, 0, 0, 1, v);
    endtask

    task automatic mtc(input logic [4:0] a, input logic [31:0] wd);
        step(0, 0, 0, 0, 0, 0, 1, a, wd, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs with each queued expectation once they have settled
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 4;
                if (cp0_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata[addr=%0d] got %h exp %h at %0t", e.addr, cp0_rdata, e.rdata, $time);
                end
                if (cp0_epc !== e.epc) begin
                    errors++;
                    $display("FAIL cp0_epc got %h exp %h at %0t", cp0_epc, e.epc, $time);
                end
                if (has_int !== e.hint) begin
                    errors++;
                    $display("FAIL has_int got %b exp %b at %0t", has_int, e.hint, $time);
                end
                if (ex_entry !== 32'hBFC0_0380) begin
                    errors++;
                    $display("FAIL ex_entry got %h exp %h", ex_entry, 32'hBFC0_0380);
                end
            end
        end
    end

    initial begin
        logic [4:0]  addrs [8];
        logic [4:0]  a;
        logic [4:0]  code;
        logic [31:0] wd;
        bit ex, we, er;
        m_reset();

        // Reset state
        rst_req = 1;
        idle_c(CR_STATUS, 32'h0040_0000);
        idle_c(CR_CAUSE, 32'h0000_0000);
        rst_req = 0;
        idle_c(CR_STATUS, 32'h0040_0000);

        // First-level exception in a delay slot with an address error
        step(1, EXC_ADEL, 1, 32'hBFC0_1004, 32'h1, 0, 0, CR_CAUSE, 0, 0, 0, 0);
        idle_c(CR_EPC, 32'hBFC0_1000);
        idle_c(CR_BADVADDR, 32'h0000_0001);
        idle_c(CR_STATUS, 32'h0040_0002);
        idle(CR_CAUSE);

        // Nested exception keeps EPC
        step(1, EXC_SYS, 0, 32'h8000_0000, 32'h55, 0, 0, CR_CAUSE, 0, 0, 0, 0);
        idle_c(CR_EPC, 32'hBFC0_1000);
        idle_c(CR_BADVADDR, 32'h0000_0001);
        idle(CR_CAUSE);
        step(0, 0, 0, 0, 0, 1, 0, CR_STATUS, 0, 0, 0, 0);
        idle_c(CR_STATUS, 32'h0040_0000);

        // Exception beats MTC0 and ERET in the same cycle
        step(1, EXC_INT, 0, 32'h8000_0010, 0, 0, 1, CR_STATUS, 32'h0000_FF01, 0, 0, 0);
        idle_c(CR_STATUS, 32'h0040_0002);
        step(1, EXC_BP, 0, 32'h8000_0020, 0, 1, 0, CR_STATUS, 0, 0, 0, 0);
        idle_c(CR_STATUS, 32'h0040_0002);
        step(0, 0, 0, 0, 0, 1, 0, CR_STATUS, 0, 0, 0, 0);

        // Timer interrupt through IM7
        mtc(CR_STATUS, 32'h0000_8001);
        mtc(CR_COMPARE, 32'd10);
        mtc(CR_COUNT, 32'd0);
        for (int i = 0; i < 24; i++) idle(CR_CAUSE);
        mtc(CR_COMPARE, 32'h0010_0000);
        for (int i = 0; i < 3; i++) idle(CR_CAUSE);

        // Software interrupt via Cause IP0, masked by EXL
        mtc(CR_STATUS, 32'h0000_0101);
        mtc(CR_CAUSE, 32'h0000_0100);
        idle(CR_CAUSE);
        step(1, EXC_SYS, 0, 32'h8000_0100, 0, 0, 0, CR_CAUSE, 0, 0, 0, 0);
        idle(CR_STATUS);
        step(0, 0, 0, 0, 0, 1, 0, CR_STATUS, 0, 0, 0, 0);
        idle(CR_STATUS);

        // Randomized traffic with a mid-run reset
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
        for (int i = 0; i < 3000; i++) begin
            rst_req = (i >= 1500 && i < 1502);
            ex = ($urandom % 10) == 0;
            code = (($urandom % 3) == 0) ? 5'(4 + $urandom % 2) : 5'($urandom % 32);
            we = ($urandom % 3) == 0;
            er = !we && (($urandom % 12) == 0);
            a = addrs[$urandom % 8];
            if (a == 5'd3) a = 5'($urandom % 32);
            wd = $urandom;
            if (a == CR_COMPARE && ($urandom % 2) == 0) wd = m_count + $urandom_range(0, 6);
            if (a == CR_COUNT && ($urandom % 2) == 0) wd = m_compare - $urandom_range(0, 6);
            if (a == CR_STATUS) wd[1] = m_exl;
            step(ex, code, 1'($urandom % 2), $urandom, $urandom, er, we, a, wd,
                 6'($urandom & $urandom), 0, 0);
        end

        repeat (2) @(negedge clk);
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
